// File: rtl/mdu_sequencer.sv
// Sequencer for the EXE-stage multiply/divide unit: issues one multiplier or divider
// operation per instruction, stalls the pipe until the result lands, then writes HI/LO once.
module mdu_sequencer #(
    parameter int unsigned MUL_LAT = 2,
    parameter int unsigned CNT_W   = 3
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic [3:0]  exe_op,
    input  logic        exe_adv,
    input  logic [31:0] src_a,
    input  logic [31:0] src_b,
    input  logic        flush,
    output logic        mul_start,
    output logic        mul_signed,
    input  logic [63:0] mul_prod,
    output logic        div_start,
    output logic        div_signed,
    output logic        div_abort,
    input  logic        div_done,
    input  logic [31:0] div_quot,
    input  logic [31:0] div_rem,
    output logic        mdu_stall,
    output logic        hilo_we,
    output logic [1:0]  hilo_acc,
    output logic [31:0] hilo_hi,
    output logic [31:0] hilo_lo
);

    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MADD  = 4'd5;
    localparam logic [3:0] OP_MADDU = 4'd6;
    localparam logic [3:0] OP_MSUB  = 4'd7;
    localparam logic [3:0] OP_MSUBU = 4'd8;

    localparam logic [1:0] ACC_SET = 2'b00;
    localparam logic [1:0] ACC_ADD = 2'b01;
    localparam logic [1:0] ACC_SUB = 2'b10;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_MUL  = 3'd1,
        S_DIV  = 3'd2,
        S_DONE = 3'd3,
        S_HOLD = 3'd4
    } state_t;

    state_t             state_q;
    state_t             state_d;
    logic [CNT_W-1:0]   cnt_q;
    logic               sgn_q;
    logic [1:0]         acc_q;
    logic [31:0]        hi_q;
    logic [31:0]        lo_q;

    logic               op_mul;
    logic               op_div;
    logic               op_sgn;
    logic [1:0]         op_acc;
    logic               op_valid;
    logic               issue;
    logic               div_zero;
    logic               cnt_zero;

    // Opcode decode; unused encodings fall through as NONE
    always_comb begin
        op_mul = 1'b0;
        op_div = 1'b0;
        op_sgn = 1'b0;
        op_acc = ACC_SET;
        case (exe_op)
            OP_MULT:  begin op_mul = 1'b1; op_sgn = 1'b1; end
            OP_MULTU: op_mul = 1'b1;
            OP_DIV:   begin op_div = 1'b1; op_sgn = 1'b1; end
            OP_DIVU:  op_div = 1'b1;
            OP_MADD:  begin op_mul = 1'b1; op_sgn = 1'b1; op_acc = ACC_ADD; end
            OP_MADDU: begin op_mul = 1'b1; op_acc = ACC_ADD; end
            OP_MSUB:  begin op_mul = 1'b1; op_sgn = 1'b1; op_acc = ACC_SUB; end
            OP_MSUBU: begin op_mul = 1'b1; op_acc = ACC_SUB; end
            default:  ;
        endcase
    end

    // Reset gates the issue path so every output reads 0 while resetn is low
    assign op_valid = op_mul | op_div;
    assign issue    = resetn & (state_q == S_IDLE) & op_valid & ~flush;
    assign div_zero = (src_b == 32'd0);
    assign cnt_zero = (cnt_q == '0);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Flush overrides every transition, including a coincident result
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (issue) begin
                    if (op_mul)        state_d = S_MUL;
                    else if (div_zero) state_d = S_DONE;
                    else               state_d = S_DIV;
                end
            end
            S_MUL: begin
                if (flush)         state_d = S_IDLE;
                else if (cnt_zero) state_d = S_DONE;
            end
            S_DIV: begin
                if (flush)         state_d = S_IDLE;
                else if (div_done) state_d = S_DONE;
            end
            S_DONE: begin
                if (flush | exe_adv) state_d = S_IDLE;
                else                 state_d = S_HOLD;
            end
            S_HOLD: begin
                if (flush | exe_adv) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        mul_start  = issue & op_mul;
        div_start  = issue & op_div & ~div_zero;
        mul_signed = (mul_start & op_sgn) | ((state_q == S_MUL) & sgn_q);
        div_signed = (div_start & op_sgn) | ((state_q == S_DIV) & sgn_q);
        div_abort  = (state_q == S_DIV) & flush;
        hilo_we    = (state_q == S_DONE) & ~flush;
        mdu_stall  = resetn & op_valid & ~flush &
                     ((state_q == S_IDLE) | (state_q == S_MUL) | (state_q == S_DIV));
        hilo_acc   = acc_q;
        hilo_hi    = hi_q;
        hilo_lo    = lo_q;
    end

    // Op attributes latched at issue; result captured only when not flushed
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cnt_q <= '0;
            sgn_q <= 1'b0;
            acc_q <= ACC_SET;
            hi_q  <= 32'd0;
            lo_q  <= 32'd0;
        end else begin
            if (issue) begin
                sgn_q <= op_sgn;
                acc_q <= op_acc;
            end
            case (state_q)
                S_IDLE: begin
                    if (issue) begin
                        if (op_mul) begin
                            cnt_q <= CNT_W'(MUL_LAT - 1);
                        end else if (div_zero) begin
                            hi_q <= src_a;
                            lo_q <= 32'hFFFF_FFFF;
                        end
                    end
                end
                S_MUL: begin
                    if (!cnt_zero) begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end else if (!flush) begin
                        hi_q <= mul_prod[63:32];
                        lo_q <= mul_prod[31:0];
                    end
                end
                S_DIV: begin
                    if (div_done && !flush) begin
                        hi_q <= div_rem;
                        lo_q <= div_quot;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mdu_sequencer.sv
// Bench for mdu_sequencer: behavioural multiplier pipe, hand-driven divider handshake,
// and a queue of required HI/LO writes checked whenever hilo_we fires.
module tb_mdu_sequencer;

    localparam int unsigned MUL_LAT = 2;
    localparam int unsigned CNT_W   = 3;

    localparam logic [3:0] OP_NONE  = 4'd0;
    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MADD  = 4'd5;
    localparam logic [3:0] OP_MSUBU = 4'd8;

    typedef struct packed {
        logic [31:0] hi;
        logic [31:0] lo;
        logic [1:0]  acc;
    } exp_t;

    logic        clk;
    logic        resetn;
    logic [3:0]  exe_op;
    logic        exe_adv;
    logic [31:0] src_a;
    logic [31:0] src_b;
    logic        flush;
    logic        mul_start;
    logic        mul_signed;
    logic [63:0] mul_prod;
    logic        div_start;
    logic        div_signed;
    logic        div_abort;
    logic        div_done;
    logic [31:0] div_quot;
    logic [31:0] div_rem;
    logic        mdu_stall;
    logic        hilo_we;
    logic [1:0]  hilo_acc;
    logic [31:0] hilo_hi;
    logic [31:0] hilo_lo;

    int   tests_run = 0;
    int   fails     = 0;
    exp_t sb_q[$];
    exp_t mon_e;
    logic [63:0] mul_pipe [MUL_LAT];

    mdu_sequencer #(.MUL_LAT(MUL_LAT), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .resetn     (resetn),
        .exe_op     (exe_op),
        .exe_adv    (exe_adv),
        .src_a      (src_a),
        .src_b      (src_b),
        .flush      (flush),
        .mul_start  (mul_start),
        .mul_signed (mul_signed),
        .mul_prod   (mul_prod),
        .div_start  (div_start),
        .div_signed (div_signed),
        .div_abort  (div_abort),
        .div_done   (div_done),
        .div_quot   (div_quot),
        .div_rem    (div_rem),
        .mdu_stall  (mdu_stall),
        .hilo_we    (hilo_we),
        .hilo_acc   (hilo_acc),
        .hilo_hi    (hilo_hi),
        .hilo_lo    (hilo_lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Multiplier device model: product appears MUL_LAT cycles after mul_start, garbage otherwise
    function automatic logic [63:0] mul_model(input logic [31:0] a, input logic [31:0] b, input logic s);
        logic [63:0] ea;
        logic [63:0] eb;
        ea = s ? {{32{a[31]}}, a} : {32'd0, a};
        eb = s ? {{32{b[31]}}, b} : {32'd0, b};
        return ea * eb;
    endfunction

    always @(posedge clk) begin
        mul_pipe[0] <= mul_start ? mul_model(src_a, src_b, mul_signed) : 64'hBAD0_BAD0_BAD0_BAD0;
        for (int i = 1; i < MUL_LAT; i++) mul_pipe[i] <= mul_pipe[i-1];
    end
    assign mul_prod = mul_pipe[MUL_LAT-1];

    // Scoreboard: every HI/LO write must match the oldest required write
    always @(negedge clk) begin
        #2;
        if (resetn && hilo_we) begin
            tests_run++;
            if (sb_q.size() == 0) begin
                fails++;
                $display("FAIL hilo_write: unexpected write hi=%h lo=%h acc=%b, none required", hilo_hi, hilo_lo, hilo_acc);
            end else begin
                mon_e = sb_q.pop_front();
                if ({hilo_hi, hilo_lo, hilo_acc} !== {mon_e.hi, mon_e.lo, mon_e.acc}) begin
                    fails++;
                    $display("FAIL hilo_write: got hi=%h lo=%h acc=%b, required hi=%h lo=%h acc=%b",
                             hilo_hi, hilo_lo, hilo_acc, mon_e.hi, mon_e.lo, mon_e.acc);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        exe_op  = op;
        src_a   = a;
        src_b   = b;
        exe_adv = 1'b0;
        flush   = 1'b0;
        #1;
    endtask

    // Called in the write cycle: advance EXE, then present a bubble
    task automatic retire();
        exe_adv = 1'b1;
        @(negedge clk);
        exe_op  = OP_NONE;
        exe_adv = 1'b0;
    endtask

    task automatic wait_we(input int budget, output int stalls, output int starts, output bit got);
        stalls = 0;
        starts = 0;
        got    = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            #1;
            if (hilo_we) begin
                got = 1'b1;
                break;
            end
            if (mdu_stall) stalls++;
            if (mul_start || div_start) starts++;
        end
    endtask

    task automatic test_reset();
        resetn = 1'b0; exe_op = OP_MULT; exe_adv = 1'b0; flush = 1'b0;
        src_a = 32'd3; src_b = 32'd4; div_done = 1'b0;
        div_quot = 32'hDEAD_BEEF; div_rem = 32'hDEAD_BEEF;
        repeat (2) @(negedge clk);
        #1;
        tests_run++;
        if ({mdu_stall, mul_start, div_start, div_abort} !== 4'b0) begin
            fails++;
            $display("FAIL reset_ctrl: got stall/mstart/dstart/abort=%b, required 0000", {mdu_stall, mul_start, div_start, div_abort});
        end
        tests_run++;
        if ({hilo_we, hilo_acc, hilo_hi, hilo_lo, mul_signed, div_signed} !== 69'd0) begin
            fails++;
            $display("FAIL reset_data: got we=%b acc=%b hi=%h lo=%h, required all 0", hilo_we, hilo_acc, hilo_hi, hilo_lo);
        end
        @(negedge clk);
        exe_op = OP_NONE;
        resetn = 1'b1;
    endtask

    task automatic test_illegal_op();
        @(negedge clk);
        exe_op = 4'd12;
        #1;
        tests_run++;
        if ({mdu_stall, mul_start, div_start} !== 3'b000) begin
            fails++;
            $display("FAIL illegal_op: got stall/mstart/dstart=%b, required 000", {mdu_stall, mul_start, div_start});
        end
        repeat (2) @(negedge clk);
        exe_op = OP_NONE;
    endtask

    task automatic test_mult();
        int stalls; int starts; bit got;
        issue(OP_MULT, 32'hFFFF_FFFD, 32'd7);
        tests_run++;
        if ({mul_start, mul_signed, mdu_stall, div_start} !== 4'b1110) begin
            fails++;
            $display("FAIL mult_issue: got mstart/msgn/stall/dstart=%b, required 1110", {mul_start, mul_signed, mdu_stall, div_start});
        end
        sb_q.push_back({32'hFFFF_FFFF, 32'hFFFF_FFEB, 2'b00});
        wait_we(20, stalls, starts, got);
        tests_run++;
        if (!got || stalls != MUL_LAT || starts != 0) begin
            fails++;
            $display("FAIL mult_latency: got we=%0d stalls=%0d restarts=%0d, required 1 %0d 0", got, stalls, starts, MUL_LAT);
        end
        tests_run++;
        if (mdu_stall !== 1'b0) begin
            fails++;
            $display("FAIL mult_done_stall: got %b, required 0", mdu_stall);
        end
        retire();
    endtask

    task automatic test_divu();
        int stalls = 0; int starts = 0;
        issue(OP_DIVU, 32'd100, 32'd7);
        tests_run++;
        if ({div_start, div_signed, mul_start, mdu_stall} !== 4'b1001) begin
            fails++;
            $display("FAIL divu_issue: got dstart/dsgn/mstart/stall=%b, required 1001", {div_start, div_signed, mul_start, mdu_stall});
        end
        sb_q.push_back({32'd2, 32'd14, 2'b00});
        for (int i = 1; i <= 33; i++) begin
            @(negedge clk);
            if (i == 33) begin
                div_done = 1'b1; div_quot = 32'd14; div_rem = 32'd2;
            end
            #1;
            if (mdu_stall) stalls++;
            if (mul_start || div_start || hilo_we) starts++;
        end
        @(negedge clk);
        div_done = 1'b0; div_quot = 32'hDEAD_BEEF; div_rem = 32'hDEAD_BEEF;
        #1;
        tests_run++;
        if (stalls != 33 || starts != 0) begin
            fails++;
            $display("FAIL divu_wait: got stalls=%0d stray=%0d, required 33 0", stalls, starts);
        end
        tests_run++;
        if ({hilo_we, mdu_stall} !== 2'b10) begin
            fails++;
            $display("FAIL divu_done: got we/stall=%b, required 10", {hilo_we, mdu_stall});
        end
        retire();
    endtask

    task automatic test_div_zero();
        issue(OP_DIV, 32'd5, 32'd0);
        tests_run++;
        if ({div_start, mul_start, mdu_stall} !== 3'b001) begin
            fails++;
            $display("FAIL divz_issue: got dstart/mstart/stall=%b, required 001", {div_start, mul_start, mdu_stall});
        end
        sb_q.push_back({32'd5, 32'hFFFF_FFFF, 2'b00});
        @(negedge clk);
        #1;
        tests_run++;
        if ({hilo_we, mdu_stall, div_start} !== 3'b100) begin
            fails++;
            $display("FAIL divz_done: got we/stall/dstart=%b, required 100", {hilo_we, mdu_stall, div_start});
        end
        retire();
    endtask

    task automatic test_madd_hold();
        int stalls; int starts; bit got; int we_cnt;
        issue(OP_MADD, 32'd2, 32'd3);
        sb_q.push_back({32'd0, 32'd6, 2'b01});
        wait_we(20, stalls, starts, got);
        we_cnt = got ? 1 : 0;
        stalls = 0;
        starts = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            #1;
            if (hilo_we) we_cnt++;
            if (mul_start || div_start) starts++;
            if (mdu_stall) stalls++;
        end
        tests_run++;
        if (we_cnt != 1 || starts != 0 || stalls != 0) begin
            fails++;
            $display("FAIL madd_hold: got writes=%0d restarts=%0d stalls=%0d, required 1 0 0", we_cnt, starts, stalls);
        end
        @(negedge clk);
        exe_adv = 1'b1;
        #1;
        tests_run++;
        if (hilo_we !== 1'b0) begin
            fails++;
            $display("FAIL madd_leave: got we=%b, required 0", hilo_we);
        end
        @(negedge clk);
        exe_op = OP_NONE; exe_adv = 1'b0;
    endtask

    task automatic test_flush_div();
        issue(OP_DIV, 32'd9, 32'd2);
        tests_run++;
        if ({div_start, div_signed} !== 2'b11) begin
            fails++;
            $display("FAIL fdiv_issue: got dstart/dsgn=%b, required 11", {div_start, div_signed});
        end
        repeat (3) @(negedge clk);
        #1;
        tests_run++;
        if ({div_signed, div_start, div_abort} !== 3'b100) begin
            fails++;
            $display("FAIL fdiv_busy: got dsgn/dstart/abort=%b, required 100", {div_signed, div_start, div_abort});
        end
        @(negedge clk);
        flush = 1'b1; div_done = 1'b1; div_quot = 32'd4; div_rem = 32'd1;
        #1;
        tests_run++;
        if ({div_abort, hilo_we, mdu_stall} !== 3'b100) begin
            fails++;
            $display("FAIL fdiv_flush: got abort/we/stall=%b, required 100", {div_abort, hilo_we, mdu_stall});
        end
        @(negedge clk);
        flush = 1'b0; div_done = 1'b0; div_quot = 32'hDEAD_BEEF; div_rem = 32'hDEAD_BEEF;
        exe_op = OP_DIVU; src_a = 32'd1; src_b = 32'd0;
        #1;
        tests_run++;
        if ({div_abort, hilo_we, mdu_stall} !== 3'b001) begin
            fails++;
            $display("FAIL fdiv_idle: got abort/we/stall=%b, required 001", {div_abort, hilo_we, mdu_stall});
        end
        sb_q.push_back({32'd1, 32'hFFFF_FFFF, 2'b00});
        @(negedge clk);
        #1;
        tests_run++;
        if (hilo_we !== 1'b1) begin
            fails++;
            $display("FAIL fdiv_next: got we=%b, required 1", hilo_we);
        end
        retire();
    endtask

    task automatic test_flush_mul();
        issue(OP_MULT, 32'd4, 32'd4);
        @(negedge clk);
        @(negedge clk);
        flush = 1'b1;
        #1;
        tests_run++;
        if ({hilo_we, mdu_stall, div_abort} !== 3'b000) begin
            fails++;
            $display("FAIL fmul_flush: got we/stall/abort=%b, required 000", {hilo_we, mdu_stall, div_abort});
        end
        @(negedge clk);
        flush = 1'b0; exe_op = OP_NONE;
        #1;
        tests_run++;
        if (hilo_we !== 1'b0) begin
            fails++;
            $display("FAIL fmul_discard: got we=%b, required 0", hilo_we);
        end
    endtask

    task automatic test_back_to_back();
        int stalls; int starts; bit got;
        issue(OP_MULT, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        sb_q.push_back({32'd0, 32'd1, 2'b00});
        wait_we(20, stalls, starts, got);
        exe_adv = 1'b1;
        @(negedge clk);
        exe_op = OP_MSUBU; src_a = 32'h0001_0000; src_b = 32'h0001_0000; exe_adv = 1'b0;
        #1;
        tests_run++;
        if ({got, mul_start, mul_signed, mdu_stall} !== 4'b1101) begin
            fails++;
            $display("FAIL b2b_issue: got we/mstart/msgn/stall=%b, required 1101", {got, mul_start, mul_signed, mdu_stall});
        end
        sb_q.push_back({32'd1, 32'd0, 2'b10});
        wait_we(20, stalls, starts, got);
        tests_run++;
        if (!got || stalls != MUL_LAT) begin
            fails++;
            $display("FAIL b2b_second: got we=%0d stalls=%0d, required 1 %0d", got, stalls, MUL_LAT);
        end
        retire();
    endtask

    task automatic test_reset_mid();
        int stalls; int starts; bit got;
        issue(OP_MULT, 32'd7, 32'd7);
        @(negedge clk);
        #1;
        resetn = 1'b0;
        #1;
        tests_run++;
        if ({mdu_stall, mul_start, mul_signed, hilo_we, div_abort} !== 5'b0) begin
            fails++;
            $display("FAIL rmid_ctrl: got stall/mstart/msgn/we/abort=%b, required 00000", {mdu_stall, mul_start, mul_signed, hilo_we, div_abort});
        end
        tests_run++;
        if ({hilo_acc, hilo_hi, hilo_lo} !== 66'd0) begin
            fails++;
            $display("FAIL rmid_data: got acc=%b hi=%h lo=%h, required 0", hilo_acc, hilo_hi, hilo_lo);
        end
        @(negedge clk);
        exe_op = OP_NONE;
        @(negedge clk);
        resetn = 1'b1;
        issue(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        sb_q.push_back({32'hFFFF_FFFE, 32'd1, 2'b00});
        wait_we(20, stalls, starts, got);
        tests_run++;
        if (!got) begin
            fails++;
            $display("FAIL rmid_multu: got no write within budget, required one");
        end
        retire();
    endtask

    initial begin
        test_reset();
        test_illegal_op();
        test_mult();
        test_divu();
        test_div_zero();
        test_madd_hold();
        test_flush_div();
        test_flush_mul();
        test_back_to_back();
        test_reset_mid();
        repeat (3) @(negedge clk);
        tests_run++;
        if (sb_q.size() != 0) begin
            fails++;
            $display("FAIL sb_drain: got %0d writes outstanding, required 0", sb_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end

endmodule
